// File: rtl/num_to_seg_pkg.sv
// Shared segment codes and digit type for the two-digit 7-segment encoder.
// All codes are active-low, ordered {g,f,e,d,c,b,a}.
package num_to_seg_pkg;

   typedef logic [3:0] digit_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Index k holds the glyph for hex digit k.
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to active-low 7-segment decoder.
// Output bit order is {g,f,e,d,c,b,a}.
module hex_to_seg7
   import num_to_seg_pkg::*;
(
   input  digit_t     i_digit,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_HEX[i_digit];
   end

endmodule

// File: rtl/num_to_seg.sv
// Registered two-digit number to active-low 7-segment encoder with DPs.
// Define NUM2SEG_BCD_EN for decimal display (0..99, dashes above).
module num_to_seg
   import num_to_seg_pkg::*;
#(
   parameter int N_BIT              = 8,
   parameter bit LEADING_ZERO_BLANK = 1'b0
)
(
   input  logic             i_CLK,
   input  logic             i_RST,
   input  logic [N_BIT-1:0] i_num,
   input  logic [1:0]       i_DP,
   output logic [15:0]      o_SEG
);

   digit_t     dig0;
   digit_t     dig1;
   logic       dash;
   logic       blank1;
   logic [6:0] raw0;
   logic [6:0] raw1;
   logic [6:0] seg0;
   logic [6:0] seg1;
   logic [15:0] seg_d;
   logic [15:0] seg_q;

`ifdef NUM2SEG_BCD_EN
   logic [15:0] num16;
   logic [6:0]  val7;

   // Only the low 7 bits matter once the value is known to be below 100.
   always_comb begin
      num16 = 16'(i_num);
      val7  = num16[6:0];
      dash  = (num16 > 16'd99);
      dig1  = digit_t'(val7 / 7'd10);
      dig0  = digit_t'(val7 % 7'd10);
   end
`else
   logic [7:0] num8;

   always_comb begin
      num8 = 8'(i_num);
      dash = 1'b0;
      dig1 = num8[7:4];
      dig0 = num8[3:0];
   end
`endif

   hex_to_seg7 u_dec0 (
      .i_digit (dig0),
      .o_seg   (raw0)
   );

   hex_to_seg7 u_dec1 (
      .i_digit (dig1),
      .o_seg   (raw1)
   );

   always_comb begin
      blank1 = LEADING_ZERO_BLANK && !dash && (dig1 == 4'd0);
      seg0   = dash ? SEG_DASH : raw0;
      unique case (1'b1)
         dash:    seg1 = SEG_DASH;
         blank1:  seg1 = SEG_BLANK;
         default: seg1 = raw1;
      endcase
      seg_d = {~i_DP[1], seg1, ~i_DP[0], seg0};
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         seg_q <= 16'hFFFF;
      end else begin
         seg_q <= seg_d;
      end
   end

   assign o_SEG = seg_q;

endmodule

// File: tb/tb_num_to_seg.sv
// Self-checking bench for num_to_seg: behavioural model plus literal checks.
// Covers hex (default) or decimal mode when NUM2SEG_BCD_EN is defined.
module tb_num_to_seg;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  num;
   logic [1:0]  dp;
   logic [15:0] seg_a;
   logic [15:0] seg_b;
   logic [15:0] exp_a;
   logic [15:0] exp_b;
   bit          armed = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;

   logic [6:0] glyph [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   always #5 clk = ~clk;

   num_to_seg #(.N_BIT(8), .LEADING_ZERO_BLANK(1'b0)) u_dut (
      .i_CLK (clk),
      .i_RST (rst),
      .i_num (num),
      .i_DP  (dp),
      .o_SEG (seg_a)
   );

   num_to_seg #(.N_BIT(8), .LEADING_ZERO_BLANK(1'b1)) u_dut_lzb (
      .i_CLK (clk),
      .i_RST (rst),
      .i_num (num),
      .i_DP  (dp),
      .o_SEG (seg_b)
   );

   function automatic logic [15:0] model(bit lzb, int unsigned v,
                                         logic [1:0] d);
      int unsigned hi;
      int unsigned lo;
      bit          over;
      logic [6:0]  c1;
      logic [6:0]  c0;
      over = 1'b0;
`ifdef NUM2SEG_BCD_EN
      over = (v >= 100);
      hi   = over ? 0 : v / 10;
      lo   = over ? 0 : v % 10;
`else
      hi = (v / 16) % 16;
      lo = v % 16;
`endif
      if (over) begin
         c1 = 7'h3F;
         c0 = 7'h3F;
      end else begin
         c1 = (lzb && hi == 0) ? 7'h7F : glyph[hi];
         c0 = glyph[lo];
      end
      return {~d[1], c1, ~d[0], c0};
   endfunction

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      exp_a <= rst ? 16'hFFFF : model(1'b0, num, dp);
      exp_b <= rst ? 16'hFFFF : model(1'b1, num, dp);
      armed <= 1'b1;
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("model_hex", seg_a, exp_a);
         chk("model_lzb", seg_b, exp_b);
      end
   end

   task automatic drive(input logic [7:0] n, input logic [1:0] d,
                        input logic r);
      num = n;
      dp  = d;
      rst = r;
   endtask

   task automatic settle;
      @(negedge clk);
   endtask

   initial begin
      drive(8'h12, 2'b00, 1'b1);
      settle();
      chk("reset_1", seg_a, 16'hFFFF);
      settle();
      chk("reset_2", seg_a, 16'hFFFF);
      drive(8'h12, 2'b00, 1'b0);
      settle();
`ifdef NUM2SEG_BCD_EN
      chk("post_reset", seg_a, 16'hF980);
      drive(8'd42, 2'b00, 1'b0);
      settle();
      chk("bcd_42", seg_a, 16'h99A4);
      drive(8'd99, 2'b00, 1'b0);
      settle();
      chk("bcd_99", seg_a, 16'h9090);
      drive(8'd150, 2'b10, 1'b0);
      settle();
      chk("bcd_150", seg_a, 16'h3FBF);
      chk("bcd_150_lzb", seg_b, 16'h3FBF);
      drive(8'd100, 2'b00, 1'b0);
      settle();
      chk("bcd_100", seg_a, 16'hBFBF);
      drive(8'd5, 2'b00, 1'b0);
      settle();
      chk("lzb_5", seg_b, 16'hFF92);
      chk("nolzb_5", seg_a, 16'hC092);
      drive(8'd50, 2'b00, 1'b0);
      settle();
      chk("lzb_50", seg_b, 16'h92C0);
`else
      chk("post_reset", seg_a, 16'hF9A4);
      drive(8'h3A, 2'b00, 1'b0);
      settle();
      chk("hex_3a", seg_a, 16'hB088);
      drive(8'h00, 2'b11, 1'b0);
      settle();
      chk("dp_both", seg_a, 16'h4040);
      drive(8'hFF, 2'b01, 1'b0);
      settle();
      chk("dp_low", seg_a, 16'h8E0E);
      drive(8'h05, 2'b00, 1'b0);
      settle();
      chk("lzb_05", seg_b, 16'hFF92);
      chk("nolzb_05", seg_a, 16'hC092);
      drive(8'h50, 2'b00, 1'b0);
      settle();
      chk("lzb_50", seg_b, 16'h92C0);
      drive(8'h0C, 2'b10, 1'b0);
      settle();
      chk("lzb_dp_blank", seg_b, 16'h7FC6);
`endif
      for (int v = 0; v < 256; v++) begin
         drive(8'(v), 2'($urandom_range(0, 3)), 1'b0);
         settle();
      end
      drive(8'hA5, 2'b00, 1'b1);
      settle();
      chk("midrun_reset", seg_a, 16'hFFFF);
      chk("midrun_reset_lzb", seg_b, 16'hFFFF);
      for (int i = 0; i < 2000; i++) begin
         drive(8'($urandom), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 15) == 0));
         settle();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
